ritc_dac_servo: RTL and testbench

//  Closed-loop threshold servo feeding the dual-RITC DAC block's servo port; one servoed 12-bit DAC word per RITC.
//  Per rate window it compares each RITC's scaler count against a target ± deadband and steps that RITC's word.
//  It writes both words into the DAC RAM (servo slot), pulses one update and waits for the serial loader to finish.

---
 rtl/ritc_dac_servo_pkg.sv | 21 ++
 rtl/ritc_dac_servo_if.sv | 28 ++
 rtl/ritc_dac_servo_step.sv | 66 ++++++
 rtl/ritc_dac_servo.sv | 138 +++++++++++++
 tb/tb_ritc_dac_servo.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ritc_dac_servo_pkg.sv
// Shared definitions for the RITC DAC threshold servo.
// Contents: DAC/scaler widths, the DAC full-scale code, the RITC count and
// the servo FSM state type. Imported by every other file of the block.
package ritc_dac_servo_pkg;

    localparam int           DAC_BITS    = 12;
    localparam logic [11:0]  DAC_MAX     = 12'hFFF;
    localparam int           SCALER_BITS = 16;
    localparam int           NUM_RITC    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_WR_R0   = 3'd2,
        ST_WR_R1   = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_WAIT_LO = 3'd6
    } state_t;

endpackage

// File: rtl/ritc_dac_servo_if.sv
// Servo port between the threshold servo and the dual-RITC DAC block.
// Signals:
//   servo_addr   RITC select for servo_wr (0=R0, 1=R1)
//   servo_wr     one-cycle DAC RAM write strobe
//   servo_update one-cycle request to reload the DACs
//   servo        12-bit binary servo word
//   loader_busy  serial loader busy, returned by the DAC block
// Modports: master = servo side, slave = DAC block side.
interface ritc_dac_servo_if;
    import ritc_dac_servo_pkg::*;

    logic                servo_addr;
    logic                servo_wr;
    logic                servo_update;
    logic [DAC_BITS-1:0] servo;
    logic                loader_busy;

    modport master (
        output servo_addr, servo_wr, servo_update, servo,
        input  loader_busy
    );

    modport slave (
        input  servo_addr, servo_wr, servo_update, servo,
        output loader_busy
    );

endinterface

// File: rtl/ritc_dac_servo_step.sv
// Combinational servo step for one RITC: builds the no-change band
// [target-deadband, target+deadband] clamped to the 16-bit scaler range,
// compares the window count against it and moves the DAC word up or down
// by one step, saturating at 0 and DAC_MAX.
// Ports: count_i, target_i, deadband_i (16 b), value_i (12 b current word),
//        value_o (12 b next word).
// Config macro: RITC_DAC_SERVO_PROP_EN selects a step proportional to the
// band violation (excess>>4, clamped to 1..255) instead of the constant STEP.
module ritc_dac_servo_step
    import ritc_dac_servo_pkg::*;
#(
    parameter logic [11:0] STEP = 12'd8
) (
    input  logic [SCALER_BITS-1:0] count_i,
    input  logic [SCALER_BITS-1:0] target_i,
    input  logic [SCALER_BITS-1:0] deadband_i,
    input  logic [DAC_BITS-1:0]    value_i,
    output logic [DAC_BITS-1:0]    value_o
);

    logic [SCALER_BITS:0]   hi_sum;
    logic [SCALER_BITS:0]   lo_dif;
    logic [SCALER_BITS-1:0] hi_bound;
    logic [SCALER_BITS-1:0] lo_bound;
    logic                   above;
    logic                   below;
    logic [DAC_BITS-1:0]    step;
    logic [DAC_BITS:0]      up_sum;
    logic [DAC_BITS:0]      dn_dif;
`ifdef RITC_DAC_SERVO_PROP_EN
    logic [SCALER_BITS-1:0] excess;
    logic [DAC_BITS-1:0]    excess_shr;
`endif

    always_comb begin
        // 17-bit arithmetic so the band edges clamp instead of wrapping
        hi_sum   = {1'b0, target_i} + {1'b0, deadband_i};
        lo_dif   = {1'b0, target_i} - {1'b0, deadband_i};
        hi_bound = hi_sum[SCALER_BITS] ? {SCALER_BITS{1'b1}} : hi_sum[SCALER_BITS-1:0];
        lo_bound = lo_dif[SCALER_BITS] ? '0 : lo_dif[SCALER_BITS-1:0];
        above    = count_i > hi_bound;
        below    = count_i < lo_bound;

`ifdef RITC_DAC_SERVO_PROP_EN
        excess     = above ? (count_i - hi_bound) : (lo_bound - count_i);
        excess_shr = excess[SCALER_BITS-1:4];
        step       = (excess_shr > 12'd255) ? 12'd255 : excess_shr;
        if (step == 12'd0) begin
            step = 12'd1;
        end
`else
        step = STEP;
`endif

        up_sum = {1'b0, value_i} + {1'b0, step};
        dn_dif = {1'b0, value_i} - {1'b0, step};

        value_o = value_i;
        if (above) begin
            value_o = up_sum[DAC_BITS] ? DAC_MAX : up_sum[DAC_BITS-1:0];
        end else if (below) begin
            value_o = dn_dif[DAC_BITS] ? '0 : dn_dif[DAC_BITS-1:0];
        end
    end

endmodule

// File: rtl/ritc_dac_servo.sv
// Closed-loop threshold servo for the dual-RITC DAC block.
// Each accepted scaler window steps both RITC DAC words toward the target
// band, writes them into the DAC RAM servo slot (R0 then R1), pulses one
// update and waits for the serial loader to start and finish.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              servo active; when low windows are ignored uncounted
//   pause_i / paused_o    hold request, acknowledged only while idle
//   target_i, deadband_i  desired window count and half-width of the band
//   scaler_valid_i        one-cycle strobe qualifying scaler_R0_i/scaler_R1_i
//   dac                   servo port to the DAC block (ritc_dac_servo_if.master)
//   value_R0_o/value_R1_o current servoed words
//   missed_o              dropped windows, saturating at 255
// Config macro: RITC_DAC_SERVO_PROP_EN (proportional step, see _step).
module ritc_dac_servo
    import ritc_dac_servo_pkg::*;
#(
    parameter logic [11:0] INIT_VALUE   = 12'd2048,
    parameter logic [11:0] STEP         = 12'd8,
    parameter logic [3:0]  BUSY_TIMEOUT = 4'd8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   pause_i,
    output logic                   paused_o,
    input  logic [SCALER_BITS-1:0] target_i,
    input  logic [SCALER_BITS-1:0] deadband_i,
    input  logic                   scaler_valid_i,
    input  logic [SCALER_BITS-1:0] scaler_R0_i,
    input  logic [SCALER_BITS-1:0] scaler_R1_i,
    ritc_dac_servo_if.master       dac,
    output logic [DAC_BITS-1:0]    value_R0_o,
    output logic [DAC_BITS-1:0]    value_R1_o,
    output logic [7:0]             missed_o
);

    state_t                 state_reg, state_next;
    logic [3:0]             tmo_cnt_reg;
    logic [7:0]             missed_reg;
    logic [DAC_BITS-1:0]    value_reg  [NUM_RITC];
    logic [DAC_BITS-1:0]    value_next [NUM_RITC];
    logic [SCALER_BITS-1:0] scaler_w   [NUM_RITC];
    logic                   accept;
    logic                   drop;
    logic                   wr_w, addr_w, update_w;
    logic [DAC_BITS-1:0]    servo_w;

    assign scaler_w[0] = scaler_R0_i;
    assign scaler_w[1] = scaler_R1_i;

    // A window is only consumed from IDLE with no pause; any other enabled
    // window is lost and counted.
    assign accept = scaler_valid_i && enable_i && (state_reg == ST_IDLE) && !pause_i;
    assign drop   = scaler_valid_i && enable_i && !accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RITC; gi++) begin : g_ritc
            ritc_dac_servo_step #(.STEP(STEP)) u_step (
                .count_i    (scaler_w[gi]),
                .target_i   (target_i),
                .deadband_i (deadband_i),
                .value_i    (value_reg[gi]),
                .value_o    (value_next[gi])
            );

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    value_reg[gi] <= INIT_VALUE;
                end else if (state_reg == ST_CALC) begin
                    value_reg[gi] <= value_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
            missed_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            // Counts cycles spent in WAIT_HI; cleared everywhere else.
            tmo_cnt_reg <= (state_reg == ST_WAIT_HI) ? tmo_cnt_reg + 4'd1 : 4'd0;
            if (drop && (missed_reg != 8'hFF)) begin
                missed_reg <= missed_reg + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_w       = 1'b0;
        addr_w     = 1'b0;
        update_w   = 1'b0;
        servo_w    = '0;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_CALC;
            ST_CALC:   state_next = ST_WR_R0;
            ST_WR_R0: begin
                wr_w       = 1'b1;
                servo_w    = value_reg[0];
                state_next = ST_WR_R1;
            end
            ST_WR_R1: begin
                wr_w       = 1'b1;
                addr_w     = 1'b1;
                servo_w    = value_reg[1];
                state_next = ST_UPDATE;
            end
            ST_UPDATE: begin
                update_w   = 1'b1;
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // Give up on the loader after BUSY_TIMEOUT cycles so a
                // missing busy cannot stall the servo forever.
                if (dac.loader_busy || (tmo_cnt_reg == BUSY_TIMEOUT - 4'd1)) begin
                    state_next = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: if (!dac.loader_busy) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign dac.servo_wr     = wr_w;
    assign dac.servo_addr   = addr_w;
    assign dac.servo_update = update_w;
    assign dac.servo        = servo_w;
    assign paused_o         = (state_reg == ST_IDLE) && pause_i;
    assign value_R0_o       = value_reg[0];
    assign value_R1_o       = value_reg[1];
    assign missed_o         = missed_reg;

endmodule

// File: tb/tb_ritc_dac_servo.sv
module tb_ritc_dac_servo;
    import ritc_dac_servo_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b1;
    logic        pause_i = 1'b0;
    logic        paused_o;
    logic [15:0] target_i = '0;
    logic [15:0] deadband_i = '0;
    logic        scaler_valid_i = 1'b0;
    logic [15:0] scaler_R0_i = '0;
    logic [15:0] scaler_R1_i = '0;
    logic [11:0] value_R0_o, value_R1_o;
    logic [7:0]  missed_o;

    ritc_dac_servo_if dac_if ();

    ritc_dac_servo dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .pause_i        (pause_i),
        .paused_o       (paused_o),
        .target_i       (target_i),
        .deadband_i     (deadband_i),
        .scaler_valid_i (scaler_valid_i),
        .scaler_R0_i    (scaler_R0_i),
        .scaler_R1_i    (scaler_R1_i),
        .dac            (dac_if),
        .value_R0_o     (value_R0_o),
        .value_R1_o     (value_R1_o),
        .missed_o       (missed_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] t, db, r0, r1;
        logic [11:0] e0, e1;
    } vec_t;

    vec_t vecs [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents one window from IDLE and checks CALC, both writes and the
    // single update pulse. Returns with the DUT in its first WAIT_HI cycle.
    task automatic issue(input string name, input logic [15:0] t, input logic [15:0] db,
                         input logic [15:0] r0, input logic [15:0] r1,
                         input logic [11:0] e0, input logic [11:0] e1);
        target_i = t; deadband_i = db; scaler_R0_i = r0; scaler_R1_i = r1;
        scaler_valid_i = 1'b1;
        tick();
        scaler_valid_i = 1'b0;
        check({name, ".calc_wr"}, dac_if.servo_wr, 0);
        tick();
        check({name, ".wr0"}, dac_if.servo_wr, 1);
        check({name, ".addr0"}, dac_if.servo_addr, 0);
        check({name, ".data0"}, dac_if.servo, e0);
        tick();
        check({name, ".wr1"}, dac_if.servo_wr, 1);
        check({name, ".addr1"}, dac_if.servo_addr, 1);
        check({name, ".data1"}, dac_if.servo, e1);
        check({name, ".val0"}, value_R0_o, e0);
        check({name, ".val1"}, value_R1_o, e1);
        tick();
        check({name, ".upd"}, dac_if.servo_update, 1);
        tick();
        check({name, ".upd_off"}, dac_if.servo_update, 0);
        $display("[TB] window %s r0=%0d r1=%0d -> w0=%0d w1=%0d", name, r0, r1, value_R0_o, value_R1_o);
    endtask

    // Loader handshake from the first WAIT_HI cycle back to IDLE.
    task automatic finish_busy();
        dac_if.loader_busy = 1'b1;
        tick();
        tick();
        dac_if.loader_busy = 1'b0;
        tick();
    endtask

    initial begin
        logic [11:0] m0, m1;
        dac_if.loader_busy = 1'b0;

`ifdef RITC_DAC_SERVO_PROP_EN
        vecs[0] = '{16'd1000,  16'd50,  16'd2000,  16'd500,   12'd2107, 12'd2020};
        vecs[1] = '{16'd1000,  16'd50,  16'd1020,  16'd1020,  12'd2107, 12'd2020};
        vecs[2] = '{16'd1000,  16'd0,   16'd1800,  16'd1000,  12'd2157, 12'd2020};
        vecs[3] = '{16'd1000,  16'd0,   16'd1001,  16'd1000,  12'd2158, 12'd2020};
        vecs[4] = '{16'd1000,  16'd50,  16'd1050,  16'd950,   12'd2158, 12'd2020};
        vecs[5] = '{16'd65500, 16'd100, 16'd65535, 16'd65399, 12'd2158, 12'd2019};
        vecs[6] = '{16'd30,    16'd100, 16'd131,   16'd0,     12'd2159, 12'd2019};
`else
        vecs[0] = '{16'd1000,  16'd50,  16'd2000,  16'd500,   12'd2056, 12'd2040};
        vecs[1] = '{16'd1000,  16'd50,  16'd1020,  16'd1020,  12'd2056, 12'd2040};
        vecs[2] = '{16'd1000,  16'd0,   16'd1800,  16'd1000,  12'd2064, 12'd2040};
        vecs[3] = '{16'd1000,  16'd0,   16'd1001,  16'd1000,  12'd2072, 12'd2040};
        vecs[4] = '{16'd1000,  16'd50,  16'd1050,  16'd950,   12'd2072, 12'd2040};
        vecs[5] = '{16'd65500, 16'd100, 16'd65535, 16'd65399, 12'd2072, 12'd2032};
        vecs[6] = '{16'd30,    16'd100, 16'd131,   16'd0,     12'd2080, 12'd2032};
`endif

        // Reset state
        repeat (3) tick();
        check("rst.wr", dac_if.servo_wr, 0);
        check("rst.upd", dac_if.servo_update, 0);
        check("rst.addr", dac_if.servo_addr, 0);
        check("rst.servo", dac_if.servo, 0);
        check("rst.v0", value_R0_o, 2048);
        check("rst.v1", value_R1_o, 2048);
        check("rst.missed", missed_o, 0);
        check("rst.paused", paused_o, 0);
        rst_i = 1'b0;
        tick();
        $display("[TB] reset released");

        // Table-driven windows
        for (int i = 0; i < 7; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].t, vecs[i].db, vecs[i].r0, vecs[i].r1,
                  vecs[i].e0, vecs[i].e1);
            finish_busy();
        end

        // Saturation: counts 128 past the band give a step of 8 in either mode
        m0 = vecs[6].e0;
        m1 = vecs[6].e1;
        for (int i = 0; i < 260; i++) begin
            m0 = (m0 > 12'd4087) ? 12'd4095 : m0 + 12'd8;
            m1 = (m1 < 12'd8) ? 12'd0 : m1 - 12'd8;
            issue($sformatf("satA%0d", i), 16'd1000, 16'd0, 16'd1128, 16'd872, m0, m1);
            finish_busy();
        end
        for (int i = 0; i < 520; i++) begin
            m0 = (m0 < 12'd8) ? 12'd0 : m0 - 12'd8;
            m1 = (m1 > 12'd4087) ? 12'd4095 : m1 + 12'd8;
            issue($sformatf("satB%0d", i), 16'd1000, 16'd0, 16'd872, 16'd1128, m0, m1);
            finish_busy();
        end
        check("sat.v0_floor", value_R0_o, 0);
        check("sat.v1_ceil", value_R1_o, 4095);

        // Pause raised during WAIT_LO
        issue("pause", 16'd1000, 16'd0, 16'd1000, 16'd1000, 12'd0, 12'd4095);
        dac_if.loader_busy = 1'b1;
        tick();
        pause_i = 1'b1;
        check("pause.mid_seq", paused_o, 0);
        tick();
        dac_if.loader_busy = 1'b0;
        tick();
        check("pause.idle", paused_o, 1);
        scaler_valid_i = 1'b1;
        tick();
        scaler_valid_i = 1'b0;
        check("pause.missed", missed_o, 1);
        tick();
        check("pause.no_wr", dac_if.servo_wr, 0);
        check("pause.still", paused_o, 1);
        pause_i = 1'b0;
        tick();
        check("pause.release", paused_o, 0);
        $display("[TB] pause sequence missed=%0d", missed_o);

        // Disabled window: dropped silently
        enable_i = 1'b0;
        scaler_valid_i = 1'b1;
        tick();
        scaler_valid_i = 1'b0;
        check("dis.missed", missed_o, 1);
        tick();
        check("dis.no_wr", dac_if.servo_wr, 0);
        enable_i = 1'b1;
        $display("[TB] disabled window missed=%0d", missed_o);

        // Loader never busy: 8 WAIT_HI cycles, 1 WAIT_LO, then IDLE
        issue("tmo", 16'd1000, 16'd0, 16'd1000, 16'd1000, 12'd0, 12'd4095);
        repeat (8) tick();
        scaler_valid_i = 1'b1;      // sampled in WAIT_LO -> dropped
        tick();
        check("tmo.missed", missed_o, 2);
        issue("tmo_next", 16'd1000, 16'd0, 16'd1128, 16'd872, 12'd8, 12'd4087);
        finish_busy();

        // Reset in the middle of a sequence
        target_i = 16'd1000; deadband_i = 16'd0; scaler_R0_i = 16'd1128; scaler_R1_i = 16'd872;
        scaler_valid_i = 1'b1;
        tick();
        scaler_valid_i = 1'b0;
        tick();
        check("mrst.wr0", dac_if.servo_wr, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst.wr", dac_if.servo_wr, 0);
        check("mrst.v0", value_R0_o, 2048);
        check("mrst.v1", value_R1_o, 2048);
        check("mrst.missed", missed_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mrst.quiet_wr%0d", i), dac_if.servo_wr, 0);
            check($sformatf("mrst.quiet_upd%0d", i), dac_if.servo_update, 0);
        end
        $display("[TB] mid-sequence reset v0=%0d v1=%0d", value_R0_o, value_R1_o);

        // missed_o saturation
        pause_i = 1'b1;
        scaler_valid_i = 1'b1;
        repeat (260) tick();
        scaler_valid_i = 1'b0;
        check("missed.sat", missed_o, 255);
        pause_i = 1'b0;
        $display("[TB] missed saturation missed=%0d", missed_o);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
